// File: rtl/vga_pkg.sv
// vga_pkg: pattern-mode encodings and default 640x480@60 raster timing.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_WHITE = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } mode_e;

    localparam int   DEF_H_ACTIVE  = 640;
    localparam int   DEF_H_FP      = 16;
    localparam int   DEF_H_SYNC    = 96;
    localparam int   DEF_H_BP      = 48;
    localparam int   DEF_V_ACTIVE  = 480;
    localparam int   DEF_V_FP      = 10;
    localparam int   DEF_V_SYNC    = 2;
    localparam int   DEF_V_BP      = 33;
    localparam int   DEF_CLK_DIV   = 4;
    localparam int   DEF_COLOR_W   = 4;
    localparam logic DEF_SYNC_POL  = 1'b0;
    localparam int   DEF_BAR_SHIFT = 6;
    localparam int   DEF_CHK_SHIFT = 5;

    // Width of a counter spanning 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/vga_pattern.sv
// vga_pattern: combinational test-pattern decode from pixel coordinates to RGB.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int COLOR_W   = 4,
    parameter int BAR_SHIFT = 6,
    parameter int CHK_SHIFT = 5
) (
    input  mode_e              mode_sel,
    input  logic [XW-1:0]      x,
    input  logic [YW-1:0]      y,
    input  logic               active,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    // Coordinates are widened so slices past the real counter width read as zero.
    logic [63:0] x_ext_s;
    logic [63:0] y_ext_s;
    logic [2:0]  bar_s;
    logic        chk_s;

    // Pattern select and blanking outside the visible area.
    always_comb begin
        x_ext_s = 64'(x);
        y_ext_s = 64'(y);
        bar_s   = 3'(x_ext_s >> BAR_SHIFT);
        chk_s   = 1'(x_ext_s >> CHK_SHIFT) ^ 1'(y_ext_s >> CHK_SHIFT);
        red     = {COLOR_W{1'b0}};
        green   = {COLOR_W{1'b0}};
        blue    = {COLOR_W{1'b0}};
        if (active) begin
            case (mode_sel)
                MODE_WHITE: begin
                    red   = {COLOR_W{1'b1}};
                    green = {COLOR_W{1'b1}};
                    blue  = {COLOR_W{1'b1}};
                end
                MODE_BARS: begin
                    red   = {COLOR_W{bar_s[2]}};
                    green = {COLOR_W{bar_s[1]}};
                    blue  = {COLOR_W{bar_s[0]}};
                end
                MODE_CHECK: begin
                    red   = {COLOR_W{~chk_s}};
                    green = {COLOR_W{~chk_s}};
                    blue  = {COLOR_W{~chk_s}};
                end
                MODE_GRAD: begin
                    red   = COLOR_W'(x_ext_s >> 2);
                    green = COLOR_W'(y_ext_s >> 2);
                    blue  = {COLOR_W{1'b0}};
                end
                default: begin
                    red   = {COLOR_W{1'b0}};
                    green = {COLOR_W{1'b0}};
                    blue  = {COLOR_W{1'b0}};
                end
            endcase
        end else begin
            red   = {COLOR_W{1'b0}};
            green = {COLOR_W{1'b0}};
            blue  = {COLOR_W{1'b0}};
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel divider, raster counters, sync decode and registered VGA outputs.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   COLOR_W   = DEF_COLOR_W,
    parameter logic SYNC_POL  = DEF_SYNC_POL,
    parameter int   BAR_SHIFT = DEF_BAR_SHIFT,
    parameter int   CHK_SHIFT = DEF_CHK_SHIFT,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW        = clog2_min1(H_TOTAL),
    localparam int  YW        = clog2_min1(V_TOTAL)
) (
    input  logic               clock,
    input  logic               res,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);

    localparam int            DW       = clog2_min1(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0]      div_q, div_d;
    logic [XW-1:0]      hcnt_q, hcnt_d;
    logic [YW-1:0]      vcnt_q, vcnt_d;
    mode_e              mode_q, mode_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               active_q, active_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               frame_start_q, frame_start_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;

    logic               pix_en_s;
    logic               origin_s;
    logic               active_s;
    mode_e              mode_sel_s;
    logic [COLOR_W-1:0] pat_red_s, pat_green_s, pat_blue_s;

    // The frame's first pixel already decodes with the freshly latched mode,
    // so a whole frame is always drawn in one pattern.
    vga_pattern #(
        .XW        (XW),
        .YW        (YW),
        .COLOR_W   (COLOR_W),
        .BAR_SHIFT (BAR_SHIFT),
        .CHK_SHIFT (CHK_SHIFT)
    ) u_pattern (
        .mode_sel (mode_sel_s),
        .x        (hcnt_q),
        .y        (vcnt_q),
        .active   (active_s),
        .red      (pat_red_s),
        .green    (pat_green_s),
        .blue     (pat_blue_s)
    );

    // Next-state: divider, raster counters, mode latch and output decode on pix_en.
    always_comb begin
        pix_en_s      = (div_q == DIV_LAST);
        origin_s      = (hcnt_q == {XW{1'b0}}) && (vcnt_q == {YW{1'b0}});
        mode_sel_s    = (pix_en_s && origin_s) ? mode_e'(mode) : mode_q;
        active_s      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        div_d         = div_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        mode_d        = mode_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        x_d           = x_q;
        y_d           = y_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        frame_start_d = pix_en_s && origin_s;
        if (pix_en_s) begin
            div_d = {DW{1'b0}};
            if (hcnt_q == H_LAST) begin
                hcnt_d = {XW{1'b0}};
                if (vcnt_q == V_LAST) begin
                    vcnt_d = {YW{1'b0}};
                end else begin
                    vcnt_d = vcnt_q + YW'(1);
                end
            end else begin
                hcnt_d = hcnt_q + XW'(1);
            end
            mode_d   = mode_sel_s;
            hsync_d  = ((hcnt_q >= HS_START) && (hcnt_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d  = ((vcnt_q >= VS_START) && (vcnt_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
            active_d = active_s;
            x_d      = hcnt_q;
            y_d      = vcnt_q;
            red_d    = pat_red_s;
            green_d  = pat_green_s;
            blue_d   = pat_blue_s;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (res) begin
            div_q         <= {DW{1'b0}};
            hcnt_q        <= {XW{1'b0}};
            vcnt_q        <= {YW{1'b0}};
            mode_q        <= MODE_WHITE;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            x_q           <= {XW{1'b0}};
            y_q           <= {YW{1'b0}};
            frame_start_q <= 1'b0;
            red_q         <= {COLOR_W{1'b0}};
            green_q       <= {COLOR_W{1'b0}};
            blue_q        <= {COLOR_W{1'b0}};
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            mode_q        <= mode_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign active      = active_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

- Parametrised VGA raster generator that replaces the fixed all-white colour driver.
- Divides the system clock down to a pixel enable and runs horizontal/vertical counters over a configurable timing.
- Produces registered hsync/vsync, active-video, pixel coordinates and RGB from one of four runtime-selectable test patterns, with colour blanked outside the active area.
- Sits between the board clock/reset and the VGA connector pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width (lines)
- CLK_DIV, 4, system clocks per pixel (≥1; 1 = pixel enable every clock)
- COLOR_W, 4, bits per colour channel
- SYNC_POL, 0, sync active level (0 = active-low)
- BAR_SHIFT, 6, log2 colour-bar width in pixels
- CHK_SHIFT, 5, log2 checker square size in pixels
- Ports:
  - clock  in  1  system clock; all logic on rising edge
  - res  in  1  synchronous, active-high reset
  - mode  in  2  pattern select: 0 solid white, 1 colour bars, 2 checker, 3 gradient
  - hsync  out  1  horizontal sync
  - vsync  out  1  vertical sync
  - active  out  1  high while the current pixel is visible
  - x  out  clog2(H_TOTAL)  current pixel column
  - y  out  clog2(V_TOTAL)  current pixel line
  - frame_start  out  1  one-clock pulse with pixel (0,0)
  - red / green / blue  out  COLOR_W each  pixel colour

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider: counts 0..CLK_DIV-1; pix_en is high in the cycle the divider equals CLK_DIV-1.
- hcnt: advances on pix_en and wraps H_TOTAL-1→0.
- vcnt: advances when hcnt wraps, and wraps V_TOTAL-1→0.
- Sync windows:
  - hsync is at SYNC_POL when hcnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else at ~SYNC_POL.
  - vsync uses the same rule on vcnt with the vertical parameters.
- active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
- Mode latch: mode is sampled into mode_q only on the pix_en edge where hcnt=0 and vcnt=0. A mode change mid-frame takes effect at the next frame. mode_q resets to 0.
- Patterns; "F" means all ones at COLOR_W:
  - 0: all channels F.
  - 1: bar = x[BAR_SHIFT+2:BAR_SHIFT]. red = {COLOR_W{bar[2]}}, green = {COLOR_W{bar[1]}}, blue = {COLOR_W{bar[0]}}.
  - 2: x[CHK_SHIFT]^y[CHK_SHIFT] = 0 gives all F, else all 0.
  - 3: red = x[COLOR_W+1:2], green = y[COLOR_W+1:2], blue = 0.
- Blanking: RGB is forced to 0 whenever active = 0, in every mode.

## Timing
- Output registers: every output is registered and updated only on pix_en edges. Each update is decoded from the hcnt/vcnt value present at that edge, so outputs show the counted pixel one pixel period later, mutually aligned. Latency counter→pins is 1 pixel period.
- frame_start: high for exactly one clock, the clock after the pix_en edge that loads x=0, y=0.
- Reset: takes effect on the next rising edge regardless of state, including mid-line and mid-sync.
  - Divider, hcnt, vcnt, x, y and mode_q go to 0.
  - hsync and vsync go to ~SYNC_POL; active, frame_start and RGB go to 0.
- First pixel: the first pix_en after res deasserts occurs CLK_DIV clocks later and outputs pixel (0,0) with frame_start.
- Widths: counter widths are clog2 of the totals. Pattern bit slices beyond a coordinate's width read as 0.

## Structure
- Package vga_pkg holds:
  - mode encodings MODE_WHITE/MODE_BARS/MODE_CHECK/MODE_GRAD;
  - default 640x480@60 timing constants used as parameter defaults.
- Sub-module vga_pattern: purely combinational (mode_q, x, y, active) → RGB decode. The top holds the divider, counters, sync decode and output registers.

## Test plan
- Default params, CLK_DIV=4: hsync low for 384 clocks every 3200 clocks; active high for 2560 clocks per visible line.
- vsync low for 6400 clocks per frame; frame period 1,680,000 clocks; exactly one frame_start per frame.
- mode=1: pixel x=0 gives RGB 0/0/0. x=64..127 gives blue=F, red=green=0. x=448..511 gives all F. x=640..799 gives 0.
- mode switched 0→2 on line 100: white persists to the end of the frame. After the next frame_start, pixel (0,0) is F and pixel (32,0) is 0.
- res held 3 clocks at hcnt=300, vcnt=50: outputs take their reset values the next clock. The first pix_en after release outputs (0,0) with frame_start.
- CLK_DIV=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1: line period 14 clocks, frame period 98 clocks; sync windows match the formulas.
